// File: rtl/dds_pkg.sv
// Shared constants and the ROM-content helper for the multi-channel DDS.
package dds_pkg;

  // Waveform selection held in each channel's MODE register.
  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_SAW    = 2'd2;
  localparam logic [1:0] MODE_TRI    = 2'd3;

  // Configuration register addresses (address 3 is reserved).
  localparam logic [1:0] CFG_FTW  = 2'd0;
  localparam logic [1:0] CFG_POFF = 2'd1;
  localparam logic [1:0] CFG_MODE = 2'd2;

  // Sine on [0, pi/2] by Taylor series. It is only evaluated at
  // elaboration to fill the ROM, so no math library is needed in hardware.
  function automatic real sin_series(real x);
    real term;
    real acc;
    term = x;
    acc  = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Quarter-wave entry: round(full_scale * sin(2*pi*(idx+0.5)/2^lut_aw)).
  function automatic int lut_entry(int idx, int lut_aw, int out_w);
    real pi;
    real x;
    real v;
    pi = 3.14159265358979323846;
    x  = 2.0 * pi * (real'(idx) + 0.5) / (2.0 ** lut_aw);
    v  = real'((1 << (out_w - 1)) - 1) * sin_series(x);
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Registered quarter-wave sine ROM with quadrant fold and sign restore.
// Input a is the top LUT_AW phase bits; the magnitude and sign are
// registered here (pipeline stage 2) and the signed sample is formed after.
module dds_sine_lut
  import dds_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] a,
  output logic [OUT_W-1:0]  sine
);

  localparam int QN = 1 << (LUT_AW - 2);

  logic [OUT_W-1:0]  rom [QN];
  logic [LUT_AW-3:0] idx;
  logic [OUT_W-1:0]  mag_q;
  logic              neg_q;

  // ROM contents are computed at elaboration, one constant per entry.
  for (genvar g = 0; g < QN; g++) begin : g_rom
    localparam int V = lut_entry(g, LUT_AW, OUT_W);
    assign rom[g] = OUT_W'(V);
  end

  // Odd quadrants read the quarter wave backwards.
  always_comb begin
    idx = a[LUT_AW-2] ? ~a[LUT_AW-3:0] : a[LUT_AW-3:0];
  end

  // Stage 2: register the magnitude and the half-wave sign.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q <= '0;
      neg_q <= 1'b0;
    end else begin
      mag_q <= rom[idx];
      neg_q <= a[LUT_AW-1];
    end
  end

  // Second half of the period is the negated first half.
  always_comb begin
    sine = neg_q ? (~mag_q + OUT_W'(1)) : mag_q;
  end

endmodule

// File: rtl/dds_multi.sv
// Multi-channel DDS: shadow/active configuration with a global commit,
// per-channel phase accumulators, and a 3-stage waveform pipeline.
// The accumulator value updated at edge N appears on out at edge N+3;
// out_valid and wrap travel down the same pipeline so they stay aligned.
module dds_multi
  import dds_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 8,
  parameter int LUT_AW  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  sync_clr,
  input  logic                                  cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                            cfg_addr,
  input  logic [PHASE_W-1:0]                    cfg_wdata,
  input  logic                                  cfg_commit,
  output logic [NCH*OUT_W-1:0]                  out,
  output logic                                  out_valid,
  output logic [NCH-1:0]                        wrap
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [OUT_W-1:0] POS_FS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FS = ~POS_FS + OUT_W'(1);

  // Shared step flag: marks a real accumulator advance, then follows the data.
  logic step_q;
  logic s1_v;
  logic s2_v;

  // Step flag and its delay line to out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q    <= 1'b0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      step_q    <= enable & ~sync_clr;
      s1_v      <= step_q;
      s2_v      <= s1_v;
      out_valid <= s2_v;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [PHASE_W-1:0] ftw_sh;
    logic [PHASE_W-1:0] poff_sh;
    logic [1:0]         mode_sh;
    logic [PHASE_W-1:0] ftw_act;
    logic [PHASE_W-1:0] poff_act;
    logic [1:0]         mode_act;
    logic [PHASE_W-1:0] acc;
    logic               carry_q;
    logic [PHASE_W:0]   sum;
    logic               sel;
    logic [PHASE_W-1:0] s1_p;
    logic [1:0]         s1_mode;
    logic               s1_c;
    logic [1:0]         s2_mode;
    logic               s2_c;
    logic [OUT_W-1:0]   s2_sq;
    logic [OUT_W-1:0]   s2_saw;
    logic [OUT_W-1:0]   s2_tri;
    logic [OUT_W-1:0]   tri_u;
    logic [OUT_W-1:0]   sine;
    logic [OUT_W-1:0]   mux;
    logic [OUT_W-1:0]   out_q;
    logic               wrap_q;
    logic               unused_p;

    assign sel      = cfg_we && (cfg_ch == CH_W'(k));
    assign sum      = {1'b0, acc} + {1'b0, ftw_act};
    // Phase bits below the waveform/LUT slices are intentionally dropped.
    assign unused_p = ^s1_p;

    // Shadow writes; a commit in the same cycle sees the pre-write shadow.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ftw_sh   <= '0;
        poff_sh  <= '0;
        mode_sh  <= MODE_SINE;
        ftw_act  <= '0;
        poff_act <= '0;
        mode_act <= MODE_SINE;
      end else begin
        if (sel) begin
          case (cfg_addr)
            CFG_FTW:  ftw_sh  <= cfg_wdata;
            CFG_POFF: poff_sh <= cfg_wdata;
            CFG_MODE: mode_sh <= cfg_wdata[1:0];
            default:  ;
          endcase
        end
        if (cfg_commit) begin
          ftw_act  <= ftw_sh;
          poff_act <= poff_sh;
          mode_act <= mode_sh;
        end
      end
    end

    // Phase accumulator; clear beats enable, carry marks a wrap.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end else if (sync_clr) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end else if (enable) begin
        acc     <= sum[PHASE_W-1:0];
        carry_q <= sum[PHASE_W];
      end else begin
        carry_q <= 1'b0;
      end
    end

    // Stage 1: offset phase, mode and carry.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_p    <= '0;
        s1_mode <= MODE_SINE;
        s1_c    <= 1'b0;
      end else begin
        s1_p    <= acc + poff_act;
        s1_mode <= mode_act;
        s1_c    <= carry_q;
      end
    end

    dds_sine_lut #(
      .LUT_AW (LUT_AW),
      .OUT_W  (OUT_W)
    ) u_lut (
      .clk  (clk),
      .rst  (rst),
      .a    (s1_p[PHASE_W-1 -: LUT_AW]),
      .sine (sine)
    );

    // Triangle folds the second half of the period back down.
    always_comb begin
      tri_u = s1_p[PHASE_W-1] ? ~s1_p[PHASE_W-2 -: OUT_W] : s1_p[PHASE_W-2 -: OUT_W];
    end

    // Stage 2: non-sine waveforms, mode and carry alongside the ROM read.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s2_mode <= MODE_SINE;
        s2_c    <= 1'b0;
        s2_sq   <= '0;
        s2_saw  <= '0;
        s2_tri  <= '0;
      end else begin
        s2_mode <= s1_mode;
        s2_c    <= s1_c;
        s2_sq   <= s1_p[PHASE_W-1] ? NEG_FS : POS_FS;
        s2_saw  <= {~s1_p[PHASE_W-1], s1_p[PHASE_W-2 -: OUT_W-1]};
        s2_tri  <= {~tri_u[OUT_W-1], tri_u[OUT_W-2:0]};
      end
    end

    // Waveform select; mode travels with its own sample, so switches are clean.
    always_comb begin
      mux = sine;
      case (s2_mode)
        MODE_SQUARE: mux = s2_sq;
        MODE_SAW:    mux = s2_saw;
        MODE_TRI:    mux = s2_tri;
        default:     mux = sine;
      endcase
    end

    // Stage 3: output sample and wrap pulse.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        out_q  <= mux;
        wrap_q <= s2_c;
      end
    end

    assign out[k*OUT_W +: OUT_W] = out_q;
    assign wrap[k]               = wrap_q;
  end

endmodule

// File: tb/tb_dds_multi.sv
// Bench for dds_multi: directed scenarios then random traffic, checked every
// cycle against a behavioural model of the configured waveforms.
module tb_dds_multi;

  localparam int NCH     = 2;
  localparam int PHASE_W = 32;
  localparam int OUT_W   = 8;
  localparam int LUT_AW  = 8;
  localparam int EW      = 2 + NCH + NCH * OUT_W;
  localparam real PI     = 3.14159265358979323846;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic                   sync_clr;
  logic                   cfg_we;
  logic [0:0]             cfg_ch;
  logic [1:0]             cfg_addr;
  logic [PHASE_W-1:0]     cfg_wdata;
  logic                   cfg_commit;
  logic [NCH*OUT_W-1:0]   out;
  logic                   out_valid;
  logic [NCH-1:0]         wrap;

  int total;
  int bad;
  int mx0;
  int mn0;
  int wrap0_cnt;

  // Expected entries: {check_out, valid, wrap[NCH-1:0], out}.
  logic [EW-1:0] exp_q[$];

  // Model state.
  logic [31:0] m_acc [NCH];
  logic [31:0] m_ftw_sh [NCH];
  logic [31:0] m_poff_sh [NCH];
  logic [1:0]  m_mode_sh [NCH];
  logic [31:0] m_ftw [NCH];
  logic [31:0] m_poff [NCH];
  logic [1:0]  m_mode [NCH];

  dds_multi #(
    .NCH     (NCH),
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W),
    .LUT_AW  (LUT_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sync_clr   (sync_clr),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .out        (out),
    .out_valid  (out_valid),
    .wrap       (wrap)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Waveform value for a phase and mode, straight from the waveform definitions.
  function automatic logic [7:0] wave(logic [31:0] p, logic [1:0] m);
    int a;
    int u;
    int r;
    case (m)
      2'd0: begin
        a = int'(p[31:24]);
        r = rnd(127.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 256.0));
      end
      2'd1: r = (p < 32'h8000_0000) ? 127 : -127;
      2'd2: r = int'(p[31:24]) - 128;
      default: begin
        u = int'(p[30:23]);
        if (p[31]) u = 255 - u;
        r = u - 128;
      end
    endcase
    return 8'(r);
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*OUT_W-1:0] model_samples();
    logic [NCH*OUT_W-1:0] s;
    for (int k = 0; k < NCH; k++) s[k*OUT_W +: OUT_W] = wave(m_acc[k] + m_poff[k], m_mode[k]);
    return s;
  endfunction

  // Behavioural model: one step per rising edge, expected samples queued.
  always @(posedge clk or negedge rst) begin
    logic [32:0] s;
    logic [NCH-1:0] cw;
    logic stp;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_acc[k] = 0; m_ftw_sh[k] = 0; m_poff_sh[k] = 0; m_mode_sh[k] = 0;
        m_ftw[k] = 0; m_poff[k] = 0; m_mode[k] = 0;
      end
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      exp_q.push_back({1'b1, 1'b0, {NCH{1'b0}}, model_samples()});
    end else begin
      cw  = '0;
      stp = enable && !sync_clr;
      for (int k = 0; k < NCH; k++) begin
        if (sync_clr) m_acc[k] = 0;
        else if (enable) begin
          s = {1'b0, m_acc[k]} + {1'b0, m_ftw[k]};
          m_acc[k] = s[31:0];
          cw[k] = s[32];
        end
      end
      if (cfg_commit)
        for (int k = 0; k < NCH; k++) begin
          m_ftw[k] = m_ftw_sh[k]; m_poff[k] = m_poff_sh[k]; m_mode[k] = m_mode_sh[k];
        end
      if (cfg_we && int'(cfg_ch) < NCH) begin
        if (cfg_addr == 2'd0) m_ftw_sh[cfg_ch] = cfg_wdata;
        else if (cfg_addr == 2'd1) m_poff_sh[cfg_ch] = cfg_wdata;
        else if (cfg_addr == 2'd2) m_mode_sh[cfg_ch] = cfg_wdata[1:0];
      end
      exp_q.push_back({1'b1, stp, cw, model_samples()});
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      check("reset_out", 64'(out), 64'd0);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_wrap", 64'(wrap), 64'd0);
    end else if (exp_q.size() > 3) begin
      e = exp_q.pop_front();
      if (e[EW-1]) check("out", 64'(out), 64'(e[NCH*OUT_W-1:0]));
      check("out_valid", 64'(out_valid), 64'(e[EW-2]));
      check("wrap", 64'(wrap), 64'(e[NCH*OUT_W +: NCH]));
      if (out_valid) begin
        if ($signed(out[7:0]) > mx0) mx0 = $signed(out[7:0]);
        if ($signed(out[7:0]) < mn0) mn0 = $signed(out[7:0]);
      end
      if (wrap[0]) wrap0_cnt++;
    end
  end

  // Driver tasks: inputs change 2 time units after each rising edge.
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_write(int ch, logic [1:0] addr, logic [31:0] d, bit commit = 0);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_addr = addr; cfg_wdata = d; cfg_commit = commit;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic clr_pulse();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
  endtask

  initial begin
    int plus;
    rst = 1'b0; enable = 1'b0; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    total = 0; bad = 0; mx0 = -1000; mn0 = 1000; wrap0_cnt = 0;
    tick(3);

    // Hand-computed values that pin the model.
    check("pin_sine_p0", 64'(wave(32'h0, 2'd0)), 64'h02);
    check("pin_sine_q1", 64'(wave(32'h4000_0000, 2'd0)), 64'h7f);
    check("pin_sine_q2", 64'(wave(32'h8000_0000, 2'd0)), 64'hfe);
    check("pin_square", 64'(wave(32'h8000_0000, 2'd1)), 64'h81);
    check("pin_saw0", 64'(wave(32'h0, 2'd2)), 64'h80);
    check("pin_tri_mid", 64'(wave(32'h8000_0000, 2'd3)), 64'h7f);

    // Release reset with FTW=0, sine: constant 2 on both channels.
    rst = 1'b1; enable = 1'b1;
    tick(6);
    check("rst_rel_ch0", 64'(out[7:0]), 64'h02);
    check("rst_rel_ch1", 64'(out[15:8]), 64'h02);
    check("rst_rel_valid", 64'(out_valid), 64'd1);

    // Sine, one full period per 256 samples.
    cfg_write(0, 2'd0, 32'h0100_0000);
    commit();
    mx0 = -1000; mn0 = 1000; wrap0_cnt = 0;
    tick(600);
    check("sine_max", 64'(mx0), 64'(127));
    check("sine_min", 64'(mn0), 64'(-127));
    check("sine_wraps", 64'(wrap0_cnt), 64'd2);

    // Square at a quarter turn per sample.
    cfg_write(0, 2'd2, 32'd1);
    cfg_write(0, 2'd0, 32'h4000_0000);
    commit();
    tick(4);
    plus = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out[7:0] == 8'h7f) plus++;
    end
    check("square_half_pos", 64'(plus), 64'd4);

    // Phase offset: ch1 a quarter period ahead of ch0.
    cfg_write(0, 2'd0, 32'h0100_0000);
    cfg_write(0, 2'd2, 32'd0);
    cfg_write(1, 2'd0, 32'h0100_0000);
    cfg_write(1, 2'd2, 32'd0);
    cfg_write(1, 2'd1, 32'h4000_0000);
    commit();
    clr_pulse();
    tick(3);
    check("poff_ch0_p0", 64'(out[7:0]), 64'h02);
    check("poff_ch1_p0", 64'(out[15:8]), 64'h7f);
    tick(100);

    // Commit semantics: write alone, write with commit, later commit.
    cfg_write(0, 2'd0, 32'h1000_0000);
    tick(10);
    cfg_write(0, 2'd0, 32'h0200_0000, 1);
    tick(10);
    commit();
    tick(20);

    // Sawtooth with a clear pulse.
    cfg_write(0, 2'd0, 32'h0100_0000);
    cfg_write(0, 2'd2, 32'd2);
    commit();
    tick(10);
    clr_pulse();
    tick(3);
    check("saw_clr_val", 64'(out[7:0]), 64'h80);
    check("saw_clr_valid", 64'(out_valid), 64'd0);
    tick();
    check("saw_next_val", 64'(out[7:0]), 64'h81);
    check("saw_next_valid", 64'(out_valid), 64'd1);
    tick(20);

    // Reset in mid-run.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(10);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      sync_clr = ($urandom_range(0, 40) == 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_ch   = 1'($urandom_range(0, 1));
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wdata = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() >> $urandom_range(4, 12));
      cfg_commit = ($urandom_range(0, 15) == 0);
      tick();
    end
    enable = 1'b0; sync_clr = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
